// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator: one shared period counter, per-channel
// clamped targets applied (optionally slew-limited) only at period boundaries.
module servo_pwm_multi #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int PWM_FREQ = 50,
    parameter int NUM_CH   = 4,
    parameter int MIN_US   = 500,
    parameter int MAX_US   = 2500,
    parameter int RESET_US = 1500,
    parameter int SLEW_US  = 0,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [15:0]       cmd_us,
    output logic              cmd_err,
    input  logic [NUM_CH-1:0] enable,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start,
    output logic [NUM_CH-1:0] settled
);

    localparam int TICKS_US = CLK_FREQ / 1_000_000;
    localparam int PERIOD   = CLK_FREQ / PWM_FREQ;
    localparam int CNT_W    = $clog2(PERIOD);
    localparam int AC_W     = 16 + $clog2(TICKS_US);
    localparam int CMP_W    = (CNT_W > AC_W) ? CNT_W : AC_W;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);
    localparam logic [15:0]      MIN_L    = 16'(MIN_US);
    localparam logic [15:0]      MAX_L    = 16'(MAX_US);
    localparam logic [15:0]      RESET_L  = 16'(RESET_US);
    localparam logic [15:0]      SLEW_L   = 16'(SLEW_US);
    localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

    logic [CNT_W-1:0] counter_reg;
    logic             rdy_pipe_reg;
    logic             cmd_ready_reg;
    logic             cmd_err_reg;
    logic             period_start_reg;
    logic             boundary;
    logic             accept;
    logic             ch_ok;
    logic [15:0]      clamped_us;

    assign boundary  = (counter_reg == LAST_CNT);
    assign accept    = cmd_valid && cmd_ready_reg;
    assign ch_ok     = ({1'b0, cmd_ch} < NUM_CH_L);

    always_comb begin
        clamped_us = cmd_us;
        if (cmd_us < MIN_L) begin
            clamped_us = MIN_L;
        end else if (cmd_us > MAX_L) begin
            clamped_us = MAX_L;
        end
    end

    // Ready is held off for one extra cycle after reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter_reg      <= '0;
            rdy_pipe_reg     <= 1'b0;
            cmd_ready_reg    <= 1'b0;
            cmd_err_reg      <= 1'b0;
            period_start_reg <= 1'b0;
        end else begin
            counter_reg      <= boundary ? '0 : counter_reg + 1'b1;
            rdy_pipe_reg     <= 1'b1;
            cmd_ready_reg    <= rdy_pipe_reg;
            cmd_err_reg      <= accept && !ch_ok;
            period_start_reg <= (counter_reg == '0);
        end
    end

    assign cmd_ready    = cmd_ready_reg;
    assign cmd_err      = cmd_err_reg;
    assign period_start = period_start_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [CH_W-1:0] CH_IDX = CH_W'(gi);

            logic [15:0]     target_reg;
            logic [15:0]     active_reg;
            logic [15:0]     active_next;
            logic            en_lat_reg;
            logic            pwm_reg;
            logic [AC_W-1:0] active_cycles;

            always_comb begin
                active_next = target_reg;
                if (SLEW_US != 0) begin
                    if (target_reg > active_reg) begin
                        if ((target_reg - active_reg) > SLEW_L) begin
                            active_next = active_reg + SLEW_L;
                        end
                    end else if ((active_reg - target_reg) > SLEW_L) begin
                        active_next = active_reg - SLEW_L;
                    end
                end
            end

            assign active_cycles = AC_W'(active_reg) * AC_W'(TICKS_US);

            always_ff @(posedge clk) begin
                if (rst) begin
                    target_reg <= RESET_L;
                    active_reg <= RESET_L;
                    en_lat_reg <= 1'b0;
                    pwm_reg    <= 1'b0;
                end else begin
                    if (accept && ch_ok && (cmd_ch == CH_IDX)) begin
                        target_reg <= clamped_us;
                    end
                    // Width and enable only move at the boundary so a pulse
                    // in flight always completes unchanged.
                    if (boundary) begin
                        active_reg <= active_next;
                        en_lat_reg <= enable[gi];
                    end
                    pwm_reg <= en_lat_reg &&
                               (CMP_W'(counter_reg) < CMP_W'(active_cycles));
                end
            end

            assign pwm_out[gi] = pwm_reg;
            assign settled[gi] = (active_reg == target_reg);
        end
    endgenerate

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi: a 3-channel unslewed instance and a
// 4-channel slew-limited instance, scaled to 1000-cycle periods.
module tb_servo_pwm_multi;

    localparam int CLK_HZ = 2_000_000;
    localparam int PWM_HZ = 2000;
    localparam int PER    = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [1:0]  a_ch = '0;
    logic [15:0] a_us = '0;
    logic        a_err;
    logic [2:0]  a_en = 3'b111;
    logic [2:0]  a_pwm;
    logic        a_ps;
    logic [2:0]  a_set;

    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [1:0]  b_ch = '0;
    logic [15:0] b_us = '0;
    logic        b_err;
    logic [3:0]  b_en = 4'b1111;
    logic [3:0]  b_pwm;
    logic        b_ps;
    logic [3:0]  b_set;

    servo_pwm_multi #(
        .CLK_FREQ(CLK_HZ), .PWM_FREQ(PWM_HZ), .NUM_CH(3),
        .MIN_US(50), .MAX_US(400), .RESET_US(150), .SLEW_US(0)
    ) u_a (
        .clk(clk), .rst(rst), .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd_ch(a_ch), .cmd_us(a_us), .cmd_err(a_err), .enable(a_en),
        .pwm_out(a_pwm), .period_start(a_ps), .settled(a_set)
    );

    servo_pwm_multi #(
        .CLK_FREQ(CLK_HZ), .PWM_FREQ(PWM_HZ), .NUM_CH(4),
        .MIN_US(50), .MAX_US(400), .RESET_US(150), .SLEW_US(20)
    ) u_b (
        .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_ch(b_ch), .cmd_us(b_us), .cmd_err(b_err), .enable(b_en),
        .pwm_out(b_pwm), .period_start(b_ps), .settled(b_set)
    );

    // High-cycle counters per period; latched when period_start is seen.
    int   a_cnt [3];
    int   a_w   [3];
    logic a_hi  [3];
    int   b_cnt [4];
    int   b_w   [4];
    logic b_hi  [4];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                a_cnt[i] <= 0;
            end else if (a_ps) begin
                a_w[i]   <= a_cnt[i];
                a_hi[i]  <= a_pwm[i];
                a_cnt[i] <= int'(a_pwm[i]);
            end else begin
                a_cnt[i] <= a_cnt[i] + int'(a_pwm[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                b_cnt[i] <= 0;
            end else if (b_ps) begin
                b_w[i]   <= b_cnt[i];
                b_hi[i]  <= b_pwm[i];
                b_cnt[i] <= int'(b_pwm[i]);
            end else begin
                b_cnt[i] <= b_cnt[i] + int'(b_pwm[i]);
            end
        end
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns positioned mid-cycle in the period_start cycle (counter == 1).
    task automatic wait_ps();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (a_ps !== 1'b1 && n < 2 * PER);
        chk("ps_seen", 32'(a_ps), 32'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic cmd_a(input logic [1:0] ch, input logic [15:0] us);
        a_valid = 1'b1;
        a_ch    = ch;
        a_us    = us;
        step(1);
        a_valid = 1'b0;
    endtask

    task automatic cmd_b(input logic [1:0] ch, input logic [15:0] us);
        b_valid = 1'b1;
        b_ch    = ch;
        b_us    = us;
        step(1);
        b_valid = 1'b0;
    endtask

    task automatic chk_a(input string tag, input int e0, input int e1, input int e2);
        chk({tag, "_a0"}, 32'(a_w[0]), 32'(e0));
        chk({tag, "_a1"}, 32'(a_w[1]), 32'(e1));
        chk({tag, "_a2"}, 32'(a_w[2]), 32'(e2));
    endtask

    task automatic chk_b_all(input string tag, input int e);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_b%0d", tag, i), 32'(b_w[i]), 32'(e));
        end
    endtask

    task automatic release_rst();
        rst = 1'b0;
        step(1);
        chk("ps_after_rel", 32'(a_ps), 32'd1);
        chk("rdy_first", 32'(a_ready), 32'd0);
        step(1);
        chk("rdy_second", 32'(a_ready), 32'd1);
        chk("ps_one_cycle", 32'(a_ps), 32'd0);
        wait_ps();
        chk_a("first_per", 0, 0, 0);
        chk_b_all("first_per", 0);
        wait_ps();
        chk_a("default_w", 300, 300, 300);
        chk_b_all("default_w", 300);
        chk("rise_at_ps", {29'd0, a_hi[2], a_hi[1], a_hi[0]}, 32'd7);
    endtask

    int exp_b0 [6];
    int exp_b1 [6];
    int exp_s0 [6];
    int exp_s1 [6];

    initial begin
        exp_b0 = '{300, 340, 380, 420, 460, 500};
        exp_b1 = '{300, 260, 220, 200, 200, 200};
        exp_s0 = '{0, 0, 0, 0, 1, 1};
        exp_s1 = '{0, 0, 1, 1, 1, 1};

        // Reset state
        step(4);
        chk("rst_pwm_a", 32'(a_pwm), 32'd0);
        chk("rst_ps", 32'(a_ps), 32'd0);
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_settled_a", 32'(a_set), 32'd7);
        chk("rst_settled_b", 32'(b_set), 32'd15);
        release_rst();

        // Command mid-period: current pulse unchanged, low clamp next period
        step(9);
        cmd_a(2'd1, 16'd20);
        wait_ps();
        chk_a("mid_cmd_cur", 300, 300, 300);
        wait_ps();
        chk_a("clamp_low", 300, 100, 300);

        // Command in the boundary cycle applies one period later
        step(998);
        cmd_a(2'd1, 16'd1000);
        wait_ps();
        chk_a("bnd_p0", 300, 100, 300);
        wait_ps();
        chk_a("bnd_p1", 300, 100, 300);
        wait_ps();
        chk_a("clamp_high", 300, 800, 300);

        // Two commands on ch0 (second wins), zero clamp, exact MIN
        step(9);
        cmd_a(2'd0, 16'd0);
        step(9);
        cmd_a(2'd0, 16'd400);
        chk("err_valid_cmd", 32'(a_err), 32'd0);
        step(9);
        cmd_a(2'd2, 16'd0);
        step(9);
        cmd_a(2'd1, 16'd50);
        wait_ps();
        chk_a("multi_cur", 300, 800, 300);
        wait_ps();
        chk_a("multi_new", 800, 100, 100);

        // 0xFFFF clamp and an invalid channel
        step(9);
        cmd_a(2'd2, 16'hFFFF);
        step(8);
        a_valid = 1'b1;
        a_ch    = 2'd3;
        a_us    = 16'd77;
        step(1);
        a_valid = 1'b0;
        chk("err_pulse", 32'(a_err), 32'd1);
        step(1);
        chk("err_one_cycle", 32'(a_err), 32'd0);
        wait_ps();
        chk_a("inv_cur", 800, 100, 100);
        wait_ps();
        chk_a("inv_next", 800, 100, 800);
        chk("inv_settled", 32'(a_set), 32'd7);

        // Enable dropped mid-pulse
        step(99);
        a_en = 3'b011;
        wait_ps();
        chk_a("en_drop_cur", 800, 100, 800);
        wait_ps();
        chk_a("en_drop_next", 800, 100, 0);

        // Slew-limited instance: ch0 up to 250us, ch1 down to 100us
        step(9);
        cmd_b(2'd0, 16'd250);
        chk("slew_set0_cmd", 32'(b_set[0]), 32'd0);
        cmd_b(2'd1, 16'd100);
        for (int k = 0; k < 6; k++) begin
            wait_ps();
            chk($sformatf("slew_w0_%0d", k), 32'(b_w[0]), 32'(exp_b0[k]));
            chk($sformatf("slew_w1_%0d", k), 32'(b_w[1]), 32'(exp_b1[k]));
            chk($sformatf("slew_s0_%0d", k), 32'(b_set[0]), 32'(exp_s0[k]));
            chk($sformatf("slew_s1_%0d", k), 32'(b_set[1]), 32'(exp_s1[k]));
        end
        chk("slew_w3", 32'(b_w[3]), 32'd300);

        // Reset mid-pulse, then the post-reset sequence again
        step(49);
        rst  = 1'b1;
        a_en = 3'b111;
        step(1);
        chk("rst_mid_pwm_a", 32'(a_pwm), 32'd0);
        chk("rst_mid_pwm_b", 32'(b_pwm), 32'd0);
        chk("rst_mid_ready", 32'(a_ready), 32'd0);
        chk("rst_mid_set_b", 32'(b_set), 32'd15);
        step(1);
        release_rst();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
